// File: rtl/wifi_rx_depun_fifo_if.sv
// wifi_rx_depun_fifo_if: soft-bit input, depunctured pair output and status flags
interface wifi_rx_depun_fifo_if #(parameter int DATA = 3);
  logic start;
  logic [1:0] rate;
  logic we;
  logic [DATA-1:0] data_in;
  logic re;
  logic [DATA-1:0] data_out_a;
  logic [DATA-1:0] data_out_b;
  logic erase_a;
  logic erase_b;
  logic valid_out;
  logic full;
  logic empty;
  logic overflow;
  logic finished;
  modport master (
    output start, rate, we, data_in, re,
    input data_out_a, data_out_b, erase_a, erase_b, valid_out, full, empty, overflow, finished
  );
  modport slave (
    input start, rate, we, data_in, re,
    output data_out_a, data_out_b, erase_a, erase_b, valid_out, full, empty, overflow, finished
  );
endinterface

// File: rtl/wifi_rx_depun_fifo.sv
// wifi_rx_depun_fifo: buffers punctured soft bits and re-expands them into (A,B) pairs with erasures
module wifi_rx_depun_fifo #(
  parameter int DATA = 3,
  parameter int AD = 4,
  parameter int MEM = 16
) (
  input logic clk,
  input logic reset,
  wifi_rx_depun_fifo_if.slave bus
);
  logic [DATA-1:0] mem [MEM];
  logic [AD-1:0] wr_ptr, rd_ptr;
  logic [AD:0] count, need, count_nx;
  logic [2:0] ph, period;
  logic [1:0] rate_q;
  logic [DATA-1:0] w0, w1;
  logic wr_ok, issue, odd;
  assign period = rate_q == 2'd0 ? 3'd1 : rate_q == 2'd1 ? 3'd2 : rate_q == 2'd2 ? 3'd3 : 3'd5;
  assign need = ph == 3'd0 ? (AD+1)'(2) : (AD+1)'(1);
  assign bus.full = count == (AD+1)'(MEM);
  assign bus.empty = count == '0;
  assign wr_ok = bus.we && !bus.full;
  assign issue = bus.re && count >= need;
  assign count_nx = count + (AD+1)'(wr_ok) - (issue ? need : '0);
  assign w0 = mem[rd_ptr];
  assign w1 = mem[rd_ptr + 1'b1];
  // odd phases carry (bit, E); even nonzero phases carry (E, bit)
  assign odd = ph[0];
  always_ff @(posedge clk)
    if (!reset && !bus.start && wr_ok) mem[wr_ptr] <= bus.data_in;
  always_ff @(posedge clk) begin
    if (reset || bus.start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ph <= '0;
      rate_q <= reset ? 2'd0 : bus.rate;
      bus.valid_out <= 1'b0;
      bus.data_out_a <= '0;
      bus.data_out_b <= '0;
      bus.erase_a <= 1'b0;
      bus.erase_b <= 1'b0;
      bus.overflow <= 1'b0;
      bus.finished <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (bus.we && bus.full) bus.overflow <= 1'b1;
      count <= count_nx;
      bus.valid_out <= issue;
      if (issue) begin
        rd_ptr <= rd_ptr + need[AD-1:0];
        ph <= ph == period - 3'd1 ? 3'd0 : ph + 3'd1;
        bus.data_out_a <= (ph == 3'd0 || odd) ? w0 : '0;
        bus.data_out_b <= ph == 3'd0 ? w1 : odd ? '0 : w0;
        bus.erase_a <= ph != 3'd0 && !odd;
        bus.erase_b <= odd;
      end
      if (wr_ok) bus.finished <= 1'b0;
      else if (issue && count_nx == '0) bus.finished <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wifi_rx_depun_fifo.sv
// tb_wifi_rx_depun_fifo: directed scoreboard bench for the depuncturing FIFO
module tb_wifi_rx_depun_fifo;
  localparam int DW = 8;
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic ea;
    logic eb;
  } pair_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int npairs = 0;
  int mph = 0;
  int mper = 1;
  int mx = 0;
  pair_t expq[$];
  logic [DW-1:0] pend[$];
  wifi_rx_depun_fifo_if #(.DATA(DW)) bus ();
  wifi_rx_depun_fifo #(.DATA(DW), .AD(4), .MEM(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock; any pair on the output is compared against the scoreboard head
  task automatic tick();
    pair_t e;
    @(posedge clk);
    #1;
    if (bus.valid_out === 1'b1) begin
      npairs++;
      if (expq.size() == 0) chk("spurious_pair", 32'd1, 32'd0);
      else begin
        e = expq.pop_front();
        chk("pair", 32'({bus.data_out_a, bus.data_out_b, bus.erase_a, bus.erase_b}), 32'(e));
      end
    end
  endtask
  task automatic mstart(input logic [1:0] r);
    expq.delete();
    pend.delete();
    mph = 0;
    mper = r == 2'd0 ? 1 : r == 2'd1 ? 2 : r == 2'd2 ? 3 : 5;
  endtask
  task automatic mpush(input logic [DW-1:0] v);
    logic [DW-1:0] x, y;
    pend.push_back(v);
    if (mph == 0 && pend.size() == 2) begin
      x = pend.pop_front();
      y = pend.pop_front();
      expq.push_back('{x, y, 1'b0, 1'b0});
      mph = mper == 1 ? 0 : 1;
    end else if (mph != 0) begin
      x = pend.pop_front();
      if (mph % 2 == 1) expq.push_back('{x, '0, 1'b0, 1'b1});
      else expq.push_back('{'0, x, 1'b1, 1'b0});
      mph = mph + 1 == mper ? 0 : mph + 1;
    end
  endtask
  task automatic start(input logic [1:0] r);
    bus.start = 1'b1;
    bus.rate = r;
    mstart(r);
    tick();
    bus.start = 1'b0;
    npairs = 0;
  endtask
  task automatic wr(input logic [DW-1:0] v, input bit accepted);
    bus.we = 1'b1;
    bus.data_in = v;
    if (accepted) mpush(v);
    tick();
    bus.we = 1'b0;
  endtask
  task automatic drain(input bit toggle);
    for (int i = 0; i < 200 && expq.size() != 0; i++) begin
      bus.re = toggle ? ~bus.re : 1'b1;
      tick();
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.rate = 2'd0;
    bus.we = 1'b0;
    bus.data_in = '0;
    bus.re = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", 32'({bus.data_out_a, bus.data_out_b}), 32'd0);
    chk("rst_erase", 32'({bus.erase_a, bus.erase_b}), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_finished", 32'(bus.finished), 32'd1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    // rate 1/2 with latency check
    start(2'd0);
    bus.re = 1'b1;
    wr(1, 1);
    chk("r12_fin_clr", 32'(bus.finished), 32'd0);
    chk("r12_no_single", 32'(bus.valid_out), 32'd0);
    wr(2, 1);
    chk("r12_lat_n1", 32'(bus.valid_out), 32'd0);
    wr(3, 1);
    chk("r12_lat_n2", 32'(bus.valid_out), 32'd1);
    for (int i = 4; i <= 8; i++) wr(DW'(i), 1);
    drain(0);
    chk("r12_pairs", 32'(npairs), 32'd4);
    chk("r12_finished", 32'(bus.finished), 32'd1);
    chk("r12_empty", 32'(bus.empty), 32'd1);
    // rate 3/4
    start(2'd2);
    for (int i = 1; i <= 8; i++) wr(DW'(i), 1);
    drain(0);
    chk("r34_pairs", 32'(npairs), 32'd6);
    chk("r34_finished", 32'(bus.finished), 32'd1);
    // rate 5/6 with re toggling
    bus.re = 1'b0;
    start(2'd3);
    for (int i = 1; i <= 12; i++) begin
      bus.re = ~bus.re;
      wr(DW'(i), 1);
    end
    drain(1);
    chk("r56_pairs", 32'(npairs), 32'd10);
    chk("r56_empty", 32'(bus.empty), 32'd1);
    // overflow with re low
    bus.re = 1'b0;
    start(2'd0);
    for (int i = 1; i <= 16; i++) wr(DW'(i), 1);
    chk("ovf_full16", 32'(bus.full), 32'd1);
    chk("ovf_not_yet", 32'(bus.overflow), 32'd0);
    chk("ovf_stall", 32'(npairs), 32'd0);
    wr(17, 0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    drain(0);
    chk("ovf_pairs", 32'(npairs), 32'd8);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("ovf_full_clr", 32'(bus.full), 32'd0);
    chk("ovf_finished", 32'(bus.finished), 32'd1);
    // rate 2/3 continuous stream across pointer wrap
    start(2'd1);
    bus.re = 1'b1;
    mx = 0;
    for (int i = 1; i <= 40; i++) begin
      wr(DW'(i), 1);
      if (32'(dut.count) > mx) mx = 32'(dut.count);
    end
    drain(0);
    chk("r23_pairs", 32'(npairs), 32'd26);
    chk("r23_maxcount", 32'(mx), 32'd2);
    chk("r23_leftover", 32'(bus.empty), 32'd0);
    chk("r23_not_fin", 32'(bus.finished), 32'd0);
    // start mid-stream discards buffered bits and switches to 5/6
    bus.re = 1'b0;
    start(2'd0);
    for (int i = 1; i <= 5; i++) wr(DW'(i), 1);
    bus.re = 1'b1;
    start(2'd3);
    chk("st_empty", 32'(bus.empty), 32'd1);
    chk("st_valid", 32'(bus.valid_out), 32'd0);
    chk("st_finished", 32'(bus.finished), 32'd1);
    for (int i = 11; i <= 16; i++) wr(DW'(i), 1);
    drain(0);
    chk("st_pairs", 32'(npairs), 32'd5);
    chk("st_done", 32'(bus.finished), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
